// File: rtl/ps2_transmitter_if.sv
// Signal bundle between the keyboard controller logic, the PS/2 pads and ps2_transmitter.
// tx_start is a single-cycle request. It is taken only while tx_busy is low, and tx_data is captured
// on that same cycle. Each accepted byte ends with exactly one tx_done_tick or tx_error_tick, and
// tx_busy drops on the following cycle.
interface ps2_transmitter_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2_clock_drive_low;
    logic       ps2_data_drive_low;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx_error_tick;

    modport master (
        output ps2_clock, ps2_data, tx_start, tx_data,
        input  ps2_clock_drive_low, ps2_data_drive_low, tx_busy, tx_done_tick, tx_error_tick
    );

    modport slave (
        input  ps2_clock, ps2_data, tx_start, tx_data,
        output ps2_clock_drive_low, ps2_data_drive_low, tx_busy, tx_done_tick, tx_error_tick
    );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues the request and shifts a byte out on
// device clock falls. It then checks the acknowledge and drives the pads through open-drain pull-low enables.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    ps2_transmitter_if.slave bus,
    output logic [2:0]       state_o
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INHIBIT_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        REQUEST  = 3'd2,
        SEND     = 3'd3,
        WAIT_ACK = 3'd4,
        FINISH   = 3'd5
    } state_e;

    state_e        state_q;
    logic [7:0]    filter_q;
    logic [7:0]    filter_d;
    logic          f_val_q;
    logic          f_val_d;
    logic          neg_edge;
    logic [9:0]    shift_q;
    logic [3:0]    n_q;
    logic [CW-1:0] cnt_q;
    logic          clk_drive_q;
    logic          data_drive_q;
    logic          watched;
    logic          done;
    logic          ack_err;
    logic          timeout;

    // A level change counts only after 8 identical samples, so pad glitches are rejected.
    always_comb begin
        filter_d = {bus.ps2_clock, filter_q[7:1]};
        f_val_d  = f_val_q;
        if (filter_q == 8'hFF) begin
            f_val_d = 1'b1;
        end else if (filter_q == 8'h00) begin
            f_val_d = 1'b0;
        end
        neg_edge = f_val_q & ~f_val_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_q <= '0;
            f_val_q  <= 1'b0;
        end else begin
            filter_q <= filter_d;
            f_val_q  <= f_val_d;
        end
    end

    // Terminating conditions. A clock fall always takes priority over the watchdog.
    always_comb begin
        watched = (state_q == SEND) || (state_q == WAIT_ACK) || (state_q == FINISH);
        done    = (state_q == FINISH) && f_val_q && bus.ps2_data;
        ack_err = (state_q == WAIT_ACK) && neg_edge && bus.ps2_data;
        timeout = watched && !neg_edge && !done && (cnt_q == TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            clk_drive_q  <= 1'b0;
            data_drive_q <= 1'b0;
        end else if (done || ack_err || timeout) begin
            state_q      <= IDLE;
            clk_drive_q  <= 1'b0;
            data_drive_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_start) begin
                        shift_q      <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        cnt_q        <= '0;
                        clk_drive_q  <= 1'b1;
                        data_drive_q <= 1'b0;
                        state_q      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == INHIBIT_LAST) begin
                        cnt_q        <= '0;
                        data_drive_q <= 1'b1;
                        state_q      <= REQUEST;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                REQUEST: begin
                    // Releasing the clock while data stays low presents the start bit to the device.
                    clk_drive_q <= 1'b0;
                    n_q         <= 4'd10;
                    cnt_q       <= '0;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (neg_edge) begin
                        data_drive_q <= ~shift_q[0];
                        shift_q      <= {1'b1, shift_q[9:1]};
                        n_q          <= n_q - 4'd1;
                        cnt_q        <= '0;
                        if (n_q == 4'd1) begin
                            state_q <= WAIT_ACK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (neg_edge) begin
                        cnt_q   <= '0;
                        state_q <= FINISH;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FINISH: begin
                    if (neg_edge) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    clk_drive_q  <= 1'b0;
                    data_drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ps2_clock_drive_low = clk_drive_q;
    assign bus.ps2_data_drive_low  = data_drive_q;
    assign bus.tx_busy             = (state_q != IDLE);
    assign bus.tx_done_tick        = done;
    assign bus.tx_error_tick       = ack_err | timeout;
    assign state_o                 = state_q;
endmodule
